mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS core. Replaces the single-cycle opcode decoder with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back. One shared instruction/data memory port with a ready handshake lets fetch and load/store wait on slow memory. The block drives every datapath select and write-enable (PC, IR, register file, memory, ALU operand muxes) and flags illegal opcodes.

## Interface
- No parameters; all encodings are fixed.
- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; valid from the DECODE state onward.
- `funct` in 6 — IR[5:0].
- `zero` in 1 — ALU zero flag.
- `mem_ready` in 1 — memory has completed the current read or write this cycle.
- `pc_we` out 1 — PC load enable.
- `pc_src` out 2 — next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target {PC[31:28],IR[25:0],2'b00}, 11 register A (jr).
- `ir_we` out 1 — instruction register load enable.
- `iord` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_read` out 1 — memory read strobe.
- `mem_write` out 1 — memory write strobe.
- `reg_write` out 1 — register-file write enable.
- `reg_dst` out 2 — write-register select: 00 rt, 01 rd, 10 r31.
- `mem_to_reg` out 2 — write-data select: 00 ALUOut, 01 MDR, 10 PC.
- `alu_src_a` out 1 — ALU A input: 0 = PC, 1 = register A.
- `alu_src_b` out 2 — ALU B input: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2.
- `alu_op` out 2 — to the ALU control unit: 00 add, 01 subtract, 10 decode by funct.
- `state` out 4 — current state, for debug.
- `instr_done` out 1 — one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1 — sticky illegal-opcode flag.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, IEX=9, IWB=10, JMP=11, JAL=12, JR=13, TRAP=14. Code 15 is unreachable and recovers to FETCH.
- **FETCH**
  - Asserts `mem_read`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when it is 1.
- **DECODE**
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (computes the branch target into ALUOut).
  - Dispatch:
    - opcode 000000 with funct 001000 → JR.
    - opcode 000000 otherwise → REX.
    - 100011 (lw) and 101011 (sw) → MEMADR.
    - 000100 (beq) → BEQ.
    - 001000 (addi) → IEX.
    - 000010 (j) → JMP.
    - 000011 (jal) → JAL.
    - any other opcode → TRAP.
- **MEMADR**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD**: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB**: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01, `instr_done`=1.
- **MEMWR**: `mem_write`=1, `iord`=1. Holds until `mem_ready`. `instr_done` pulses in the cycle `mem_ready`=1.
- **REX**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
- **RWB**: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00, `instr_done`=1.
- **BEQ**
  - `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01.
  - `pc_we`=`zero`; `instr_done`=1.
- **IEX**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
- **IWB**: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00, `instr_done`=1.
- **JMP**: `pc_we`=1, `pc_src`=10, `instr_done`=1.
- **JAL**
  - `pc_we`=1, `pc_src`=10, `instr_done`=1.
  - `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10.
  - The register file captures the current PC (already PC+4) in the same edge that PC loads the jump target.
- **JR**: `pc_we`=1, `pc_src`=11, `instr_done`=1.
- Every state marked `instr_done` returns to FETCH. MEMWR returns to FETCH only once `mem_ready`=1.
- **TRAP**
  - `illegal`=1; every enable and strobe is 0.
  - Stays in TRAP until reset.
- Outputs not listed for a state are 0.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `state`=FETCH and `illegal`=0 immediately.
  - `pc_we`, `ir_we`, `reg_write`, `mem_write` and `instr_done` are forced to 0 while `rst_n` is low.
  - `mem_read`=1 and `alu_src_b`=01 (FETCH values); all other outputs 0.
- The first fetch begins on the first rising edge after `rst_n` deasserts.
- Reset asserted mid-instruction aborts it at once. No partial write is issued after reset asserts.
- Latency with `mem_ready` held at 1:

  | Instruction | Cycles |
  |---|---|
  | beq, j, jal, jr | 3 |
  | R-type, addi, sw | 4 |
  | lw | 5 |

  Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- All outputs are combinational from `state`. The only exceptions are `pc_we`/`ir_we` in FETCH (depend on `mem_ready`), `pc_we` in BEQ (depends on `zero`), and `instr_done` in MEMWR (depends on `mem_ready`).
- `opcode` and `funct` are sampled only in DECODE. Changes in other states have no effect.

## Test plan
- **Reset**: hold `rst_n`=0 with `mem_ready`=1 → `state`=0, `pc_we`=`ir_we`=0, `illegal`=0. Release → `ir_we`=1 on the first cycle.
- **Zero-wait sequence**: add (000000/100000), lw, sw, beq (`zero`=1 then 0), addi, j → `instr_done` gaps of 4, 5, 4, 3, 3, 4, 3 cycles. `pc_we` pulses in BEQ only when `zero`=1.
- **Memory wait**: lw with `mem_ready`=0 for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total. `mem_read` and `iord` stay stable throughout the wait. sw with 2 wait cycles → `mem_write` high for 3 cycles.
- **jal/jr**: jal → in the JAL cycle `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `pc_src`=10. jr (000000/001000) → JR state, `pc_src`=11, with no RWB state visited.
- **Illegal opcode**: opcode 111111 → TRAP after DECODE, `illegal`=1 and all enables 0 for 20 cycles. Pulsing `rst_n` clears it and fetching resumes.
- **Reset mid-operation**: assert `rst_n`=0 during MEMWR with `mem_ready`=0 → `mem_write` drops in the same cycle and `state`=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// The sequencer is the master. The datapath drives the decode and status inputs.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
           instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
           instr_done, illegal
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style multi-cycle MIPS sequencer: fetch/decode/execute/memory/write-back
// over one shared memory port with a ready handshake.
module mips_multicycle_ctrl (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                         S_REX    = 4'd6,  S_RWB    = 4'd7,  S_BEQ    = 4'd8,
                         S_IEX    = 4'd9,  S_IWB    = 4'd10, S_JMP    = 4'd11,
                         S_JAL    = 4'd12, S_JR     = 4'd13, S_TRAP   = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011,
                         OP_SW    = 6'b101011, OP_BEQ = 6'b000100,
                         OP_ADDI  = 6'b001000, OP_J   = 6'b000010,
                         OP_JAL   = 6'b000011, FN_JR  = 6'b001000;

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic       r_is_sw;
  logic       w_pc_we, w_ir_we, w_reg_write, w_mem_write, w_instr_done;

  // lw/sw is remembered at DECODE so MEMADR does not depend on a later opcode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) r_is_sw <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  if (bus.mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_state_next = (bus.funct == FN_JR) ? S_JR : S_REX;
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_BEQ:       w_state_next = S_BEQ;
          OP_ADDI:      w_state_next = S_IEX;
          OP_J:         w_state_next = S_JMP;
          OP_JAL:       w_state_next = S_JAL;
          default:      w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_state_next = r_is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) w_state_next = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) w_state_next = S_FETCH;
      S_REX:    w_state_next = S_RWB;
      S_IEX:    w_state_next = S_IWB;
      S_MEMWB, S_RWB, S_BEQ, S_IWB, S_JMP, S_JAL, S_JR: w_state_next = S_FETCH;
      S_TRAP:   w_state_next = S_TRAP;
      default:  w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_we        = 1'b0;
    w_ir_we        = 1'b0;
    w_reg_write    = 1'b0;
    w_mem_write    = 1'b0;
    w_instr_done   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        w_ir_we       = bus.mem_ready;
        w_pc_we       = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write    = 1'b1;
        bus.mem_to_reg = 2'b01;
        w_instr_done   = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write  = 1'b1;
        bus.iord     = 1'b1;
        w_instr_done = bus.mem_ready;
      end
      S_REX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_RWB: begin
        w_reg_write  = 1'b1;
        bus.reg_dst  = 2'b01;
        w_instr_done = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        w_pc_we       = bus.zero;
        w_instr_done  = 1'b1;
      end
      S_IEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_IWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JMP: begin
        w_pc_we      = 1'b1;
        bus.pc_src   = 2'b10;
        w_instr_done = 1'b1;
      end
      // Register file takes the current PC (already PC+4) on the same edge PC jumps.
      S_JAL: begin
        w_pc_we        = 1'b1;
        bus.pc_src     = 2'b10;
        w_reg_write    = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        w_instr_done   = 1'b1;
      end
      S_JR: begin
        w_pc_we      = 1'b1;
        bus.pc_src   = 2'b11;
        w_instr_done = 1'b1;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: ;
    endcase
  end

  // Write enables are masked by reset so nothing commits while rst_n is low.
  assign bus.pc_we      = w_pc_we      & i_rst_n;
  assign bus.ir_we      = w_ir_we      & i_rst_n;
  assign bus.reg_write  = w_reg_write  & i_rst_n;
  assign bus.mem_write  = w_mem_write  & i_rst_n;
  assign bus.instr_done = w_instr_done & i_rst_n;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS sequencer: latencies, state paths,
// memory stalls, jal/jr, trap and asynchronous reset behaviour.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   mw;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH until instr_done; stall_mask bit c forces
  // mem_ready low in cycle c of the instruction.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [31:0] stall_mask, input int exp_cyc,
                           input logic [15:0] exp_visit, output int mw_cyc);
    int         cyc;
    bit         seen;
    logic [15:0] visited;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    cyc = 0; seen = 0; visited = '0; mw_cyc = 0;
    while (!seen && cyc < 32) begin
      bus.mem_ready = !stall_mask[cyc];
      #1;
      visited[bus.state] = 1'b1;
      if (bus.mem_write) mw_cyc++;
      if (bus.state == 4'd8) check({name, "_beq_pcwe"}, 32'(bus.pc_we), 32'(z));
      if (bus.state == 4'd12)
        check({name, "_jal_ctl"},
              32'({bus.pc_we, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_src}),
              32'b1_1_10_10_10);
      if (bus.state == 4'd13)
        check({name, "_jr_ctl"}, 32'({bus.pc_we, bus.pc_src}), 32'b1_11);
      if (!bus.mem_ready && bus.state == 4'd0)
        check({name, "_fetch_wait"},
              32'({bus.mem_read, bus.iord, bus.ir_we, bus.pc_we, bus.instr_done}), 32'b10000);
      if (!bus.mem_ready && bus.state == 4'd3)
        check({name, "_memrd_wait"},
              32'({bus.mem_read, bus.iord, bus.mem_write, bus.instr_done}), 32'b1100);
      if (!bus.mem_ready && bus.state == 4'd5)
        check({name, "_memwr_wait"},
              32'({bus.mem_write, bus.iord, bus.mem_read, bus.instr_done}), 32'b1100);
      cyc++;
      seen = bus.instr_done;
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_states"}, 32'(visited), 32'(exp_visit));
    $display("instr %s: cycles=%0d states=%04h mem_write_cycles=%0d", name, cyc, visited, mw_cyc);
  endtask

  initial begin
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_we", 32'({bus.pc_we, bus.ir_we, bus.reg_write, bus.mem_write, bus.instr_done}), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_fetch_ctl", 32'({bus.mem_read, bus.alu_src_b, bus.iord, bus.alu_src_a, bus.alu_op, bus.pc_src}),
          32'b1_01_0_0_00_00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ir_we", 32'({bus.ir_we, bus.pc_we}), 32'b11);

    // Zero-wait sequence
    run_instr("add",    OP_R,    FN_ADD, 1'b0, 32'h0, 4, 16'h00C3, mw);
    run_instr("lw",     OP_LW,   6'h00,  1'b0, 32'h0, 5, 16'h001F, mw);
    run_instr("sw",     OP_SW,   6'h00,  1'b0, 32'h0, 4, 16'h0027, mw);
    check("sw_mw_cycles", 32'(mw), 32'd1);
    run_instr("beq_z1", OP_BEQ,  6'h00,  1'b1, 32'h0, 3, 16'h0103, mw);
    run_instr("beq_z0", OP_BEQ,  6'h00,  1'b0, 32'h0, 3, 16'h0103, mw);
    run_instr("addi",   OP_ADDI, 6'h00,  1'b0, 32'h0, 4, 16'h0603, mw);
    run_instr("j",      OP_J,    6'h00,  1'b0, 32'h0, 3, 16'h0803, mw);

    // Memory wait: lw stalls 2 in FETCH and 3 in MEMRD, sw stalls 2 in MEMWR
    run_instr("lw_wait", OP_LW, 6'h00, 1'b0, 32'h0000_00E3, 10, 16'h001F, mw);
    run_instr("sw_wait", OP_SW, 6'h00, 1'b0, 32'h0000_0018, 6,  16'h0027, mw);
    check("sw_wait_mw_cycles", 32'(mw), 32'd3);

    // jal / jr
    run_instr("jal", OP_JAL, 6'h00, 1'b0, 32'h0, 3, 16'h1003, mw);
    run_instr("jr",  OP_R,   FN_JR, 1'b0, 32'h0, 3, 16'h2003, mw);

    // Illegal opcode
    bus.opcode = OP_BAD; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    #1 check("trap_fetch", 32'(bus.state), 32'd0);
    @(negedge clk);
    #1 check("trap_decode", 32'(bus.state), 32'd1);
    @(negedge clk);
    bus.opcode = OP_R;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      bus.zero = i[1];
      #1;
      check("trap_state", 32'({bus.state, bus.illegal}), 32'b1110_1);
      check("trap_en", 32'({bus.pc_we, bus.ir_we, bus.reg_write, bus.mem_write, bus.mem_read,
                            bus.instr_done}), 32'd0);
      @(negedge clk);
    end
    $display("instr trap: held 20 cycles in TRAP");
    rst_n = 1'b0;
    #1;
    check("trap_rst", 32'({bus.state, bus.illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("add_after_trap", OP_R, FN_ADD, 1'b0, 32'h0, 4, 16'h00C3, mw);

    // Reset asserted mid-store while memory is stalled
    bus.opcode = OP_SW; bus.mem_ready = 1'b1;
    #1 check("mid_fetch", 32'(bus.state), 32'd0);
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 check("mid_memwr", 32'({bus.state, bus.mem_write}), 32'b0101_1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst", 32'({bus.state, bus.mem_write, bus.instr_done, bus.mem_read}), 32'b0000_0_0_1);
    $display("instr sw_abort: reset during MEMWR state=%0d mem_write=%0b", bus.state, bus.mem_write);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("j_after_abort", OP_J, 6'h00, 1'b0, 32'h0, 3, 16'h0803, mw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
